imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, pipelined immediate-extension stage for the processor datapath. Accepts an IN_W-bit immediate field plus a 2-bit extension mode over a valid/ready handshake, and produces the OUT_W-bit operand. The operand passes through a 2-entry output buffer, so decode-stage backpressure never drops or duplicates an immediate. It sits between instruction decode and the ALU/branch-target operand muxes.

## Interface
- IN_W, 17, width of the immediate field; 1 ≤ IN_W ≤ OUT_W−2
- OUT_W, 32, width of the extended operand
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an immediate to transfer
- in_ready  out  1  stage can accept; high when buffer occupancy < 2
- in_data  in  IN_W  raw immediate field
- in_mode  in  2  00 sign-extend, 01 zero-extend, 10 upper (left-justify), 11 branch offset
- out_valid  out  1  buffer head holds a result
- out_ready  in  1  downstream accepts the head
- out_data  out  OUT_W  extended operand at the buffer head
- out_neg  out  1  head result is negative (bit OUT_W−1 of out_data in modes 00/11; 0 otherwise)

## Operation
- Transfer in: in_valid && in_ready at a clock edge. Transfer out: out_valid && out_ready at a clock edge.
- The result is computed combinationally from in_data/in_mode and written into the buffer on transfer in. No stage after the buffer does arithmetic.
- Mode 00: out = {(OUT_W−IN_W){in_data[IN_W−1]}, in_data}.
- Mode 01: out = {(OUT_W−IN_W){1'b0}, in_data}.
- Mode 10: out = {in_data, (OUT_W−IN_W){1'b0}}.
- Mode 11: sign-extend to OUT_W, then shift left by 2. The two MSBs are discarded and bits [1:0] are 0.
- Buffer: 2-entry FIFO with a write pointer, a read pointer and a 2-bit occupancy count (0..2). Head = oldest entry. Order is strictly preserved.
- in_ready = (count != 2). It is decoded from registered count only and has no combinational path from out_ready.
- Occupancy changes:
  - Simultaneous transfer in and out at count 1: count stays 1 and the pointers both advance.
  - At count 0: only a transfer in is possible.
  - At count 2: only a transfer out is possible. in_ready is low even if out_ready is high that cycle.
- Pointers wrap modulo 2.
- out_data/out_neg are held stable while out_valid && !out_ready.

## Timing
- Latency 1 cycle: a transfer in at edge N gives out_valid high from edge N, so the result is visible during cycle N+1. There is no bypass to the same cycle.
- Throughput 1 per cycle while out_ready stays high.
- Reset (reset_n low, asynchronous):
  - count = 0, both pointers = 0.
  - out_valid = 0, out_data = 0, out_neg = 0.
  - in_ready = 1.
  - Buffer contents are discarded.
- Reset mid-operation drops all buffered entries. The first result after release requires a new transfer in.
- Illegal parameters (IN_W+2 > OUT_W) are rejected at elaboration.

## Configuration
- IMM_EXTEND_COUNT_EN defined: adds output port xfer_count [15:0].
  - Reset to 0.
  - Increments by 1 on every transfer out.
  - Saturates at 0xFFFF and does not wrap.
- IMM_EXTEND_COUNT_EN undefined: no xfer_count port and no counter logic. All other behaviour is identical.

## Test plan
- Mode sweep (IN_W=17, OUT_W=32, out_ready=1): in_data 0x10000 → modes 00/01/10/11 yield 0xFFFF0000/0x00010000/0x80000000/0xFFFC0000.
- Branch and sign edge cases: 0x1FFFF mode 11 → 0xFFFFFFFC, out_neg=1; 0x0FFFF mode 00 → 0x0000FFFF, out_neg=0.
- Latency and stream: 8 back-to-back transfers with out_ready=1 → out_valid one cycle after the first, 8 results in order with no bubbles.
- Backpressure: out_ready=0, drive 3 valid inputs A,B,C → in_ready low after A,B are accepted, C is held. Raise out_ready → A, B, C emerge in order with no loss.
- Simultaneous push/pop at count 1 → count remains 1; at count 2 with out_ready=1 → in_ready stays 0 for that cycle.
- Reset mid-stream with 2 entries buffered: assert reset_n=0 asynchronously → out_valid=0, out_data=0, in_ready=1 immediately. With IMM_EXTEND_COUNT_EN, xfer_count=0 and it saturates at 0xFFFF after 65 536 transfers.

Source files
------------

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend_pipe
//  Purpose  : Pipelined immediate-extension stage. Extends an IN_W-bit
//             immediate to OUT_W bits according to a 2-bit mode and holds
//             the result in a 2-entry output FIFO so that downstream
//             backpressure never drops or duplicates an operand.
//  Modes    : 00 sign-extend, 01 zero-extend, 10 upper (left-justify),
//             11 branch offset (sign-extend, then shift left by 2)
//  Ports    : clock, reset_n (async, active-low)
//             in_valid/in_ready/in_data[IN_W]/in_mode[2]   - upstream
//             out_valid/out_ready/out_data[OUT_W]/out_neg  - downstream
//             xfer_count[16]  - saturating count of transfers out
//                               (present only with IMM_EXTEND_COUNT_EN)
//  Options  : `define IMM_EXTEND_COUNT_EN to add the xfer_count port
//  Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
`ifdef IMM_EXTEND_COUNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    // Reject parameter sets that leave no room for the branch-offset shift.
    generate
        if (IN_W < 1 || IN_W + 2 > OUT_W) begin : g_bad_params
            $error("imm_extend_pipe: require 1 <= IN_W <= OUT_W-2");
        end
    endgenerate

    localparam logic [1:0] c_mode_sext   = 2'b00;
    localparam logic [1:0] c_mode_zext   = 2'b01;
    localparam logic [1:0] c_mode_upper  = 2'b10;
    localparam logic [1:0] c_mode_branch = 2'b11;
    localparam logic [1:0] c_count_full  = 2'd2;

    // ------------------------------------------------------------------
    // Extension datapath (combinational, ahead of the buffer)
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_result;
    logic             w_neg;

    assign w_sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

    always_comb begin
        w_result = '0;
        w_neg    = 1'b0;
        case (in_mode)
            c_mode_sext: begin
                w_result = w_sext;
                w_neg    = w_sext[OUT_W-1];
            end
            c_mode_zext: begin
                w_result = {{(OUT_W-IN_W){1'b0}}, in_data};
            end
            c_mode_upper: begin
                w_result = {in_data, {(OUT_W-IN_W){1'b0}}};
            end
            c_mode_branch: begin
                // Top two sign bits fall off; negativity is taken after the shift.
                w_result = {w_sext[OUT_W-3:0], 2'b00};
                w_neg    = w_sext[OUT_W-3];
            end
            default: begin
                w_result = '0;
                w_neg    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem [0:1];
    logic             r_neg [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (r_count != c_count_full);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign out_neg   = r_neg[r_rd_ptr];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Entries are cleared on reset so the idle head reads as zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_neg[0] <= 1'b0;
            r_neg[1] <= 1'b0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
            r_neg[r_wr_ptr] <= w_neg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IMM_EXTEND_COUNT_EN
    // ------------------------------------------------------------------
    // Saturating transfer-out counter
    // ------------------------------------------------------------------
    logic [15:0] r_xfer_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_xfer_count <= 16'd0;
        end else if (w_pop && (r_xfer_count != 16'hFFFF)) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_extend_pipe
//  Purpose  : Directed self-checking bench for imm_extend_pipe
//             (IN_W=17, OUT_W=32). Inputs are driven and outputs sampled
//             on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    localparam int IN_W  = 17;
    localparam int OUT_W = 32;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_neg;
`ifdef IMM_EXTEND_COUNT_EN
    logic [15:0]      xfer_count;
`endif

    int errors = 0;
    int checks = 0;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg)
`ifdef IMM_EXTEND_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
        checks++; if (out_neg !== 1'b0) begin errors++; $display("FAIL reset_out_neg got=%b exp=0", out_neg); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef IMM_EXTEND_COUNT_EN
        checks++; if (xfer_count !== 16'h0) begin errors++; $display("FAIL reset_xfer_count got=%h exp=0000", xfer_count); end
`endif
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // ------------------------------------------------------------------
    // One transfer per vector, out_ready high; result checked the cycle after.
    task automatic test_modes();
        logic [16:0] v_in   [10] = '{17'h10000, 17'h10000, 17'h10000, 17'h10000,
                                     17'h1FFFF, 17'h0FFFF, 17'h0FFFF, 17'h1FFFF,
                                     17'h1FFFF, 17'h00001};
        logic [1:0]  v_mode [10] = '{2'b00, 2'b01, 2'b10, 2'b11,
                                     2'b11, 2'b00, 2'b11, 2'b10,
                                     2'b01, 2'b11};
        logic [31:0] v_exp  [10] = '{32'hFFFF0000, 32'h00010000, 32'h80000000, 32'hFFFC0000,
                                     32'hFFFFFFFC, 32'h0000FFFF, 32'h0003FFFC, 32'hFFFF8000,
                                     32'h0001FFFF, 32'h00000004};
        logic        v_neg  [10] = '{1'b1, 1'b0, 1'b0, 1'b1,
                                     1'b1, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = v_in[i];
            in_mode  = v_mode[i];
            @(negedge clock);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== v_exp[i]) begin errors++; $display("FAIL mode_data[%0d] got=%h exp=%h", i, out_data, v_exp[i]); end
            checks++; if (out_neg !== v_neg[i]) begin errors++; $display("FAIL mode_neg[%0d] got=%b exp=%b", i, out_neg, v_neg[i]); end
            @(negedge clock);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode_drain[%0d] got=%b exp=0", i, out_valid); end
        end
    endtask

    // ------------------------------------------------------------------
    // 8 back-to-back transfers: one result per cycle, in order, no bubbles.
    task automatic test_back_to_back();
        logic [31:0] exp_v;
        out_ready = 1'b1;
        in_mode   = 2'b01;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                exp_v = (i - 1) * 32'h00001111 + 32'h00000100;
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i - 1, out_valid); end
                checks++; if (out_data !== exp_v) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i - 1, out_data, exp_v); end
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i - 1, in_ready); end
            end
            if (i < 8) begin
                in_valid = 1'b1;
                in_data  = 17'(i * 32'h00001111 + 32'h00000100);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    // ------------------------------------------------------------------
    // Fill with out_ready low, hold C, then drain A, B, C in order.
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 17'h00001; in_mode = 2'b01;   // A -> 00000001
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_cnt1 got=%b exp=1", in_ready); end
        in_data = 17'h12345; in_mode = 2'b00;                      // B -> FFFF2345
        @(negedge clock);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        checks++; if (out_data !== 32'h00000001) begin errors++; $display("FAIL bp_head_a got=%h exp=00000001", out_data); end
        in_data = 17'h0ABCD; in_mode = 2'b10;                      // C -> 55E68000
        @(negedge clock);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_held got=%b exp=0", in_ready); end
        checks++; if (out_data !== 32'h00000001) begin errors++; $display("FAIL bp_head_stable got=%h exp=00000001", out_data); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_pop_ready got=%b exp=0", in_ready); end
        @(negedge clock);
        checks++; if (out_data !== 32'hFFFF2345) begin errors++; $display("FAIL bp_head_b got=%h exp=FFFF2345", out_data); end
        checks++; if (out_neg !== 1'b1) begin errors++; $display("FAIL bp_neg_b got=%b exp=1", out_neg); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
        @(negedge clock);   // C pushed while B popped: occupancy stays 1
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'h55E68000) begin errors++; $display("FAIL bp_head_c got=%h exp=55E68000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_simul_cnt1 got=%b exp=1", in_ready); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    // ------------------------------------------------------------------
    // Asynchronous reset with two entries buffered.
    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 17'h1FFFF; in_mode = 2'b00;   // FFFFFFFF, neg
        repeat (2) @(negedge clock);
        in_valid = 1'b0;
        checks++; if (out_neg !== 1'b1) begin errors++; $display("FAIL rm_pre_neg got=%b exp=1", out_neg); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rm_out_data got=%h exp=00000000", out_data); end
        checks++; if (out_neg !== 1'b0) begin errors++; $display("FAIL rm_out_neg got=%b exp=0", out_neg); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_stale got=%b exp=0", out_valid); end
    endtask

`ifdef IMM_EXTEND_COUNT_EN
    // ------------------------------------------------------------------
    task automatic test_xfer_count();
        checks++; if (xfer_count !== 16'h0) begin errors++; $display("FAIL cnt_after_reset got=%h exp=0000", xfer_count); end
        out_ready = 1'b1;
        in_valid  = 1'b1; in_data = 17'h00005; in_mode = 2'b01;
        repeat (4) @(negedge clock);   // 4 pushes, 3 pops so far
        checks++; if (xfer_count !== 16'd3) begin errors++; $display("FAIL cnt_three got=%h exp=0003", xfer_count); end
        repeat (65540) @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (xfer_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got=%h exp=FFFF", xfer_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef IMM_EXTEND_COUNT_EN
        test_xfer_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
